// File: rtl/pca_pkg.sv
// Shared constants and elaboration helpers for the covariance (MEISSA) datapath blocks.
package pca_pkg;

  localparam int PCA_DATA_WIDTH = 8;
  localparam int PCA_LANE_W     = 2 * PCA_DATA_WIDTH;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Product lane width for a given operand width.
  function automatic int lane_width(input int dw);
    return 2 * dw;
  endfunction

  // Tree levels plus the output/accumulator stage.
  function automatic int adder_pipe_stages(input int n);
    return clog2(n) + 1;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered reduction level: IN_LANES unsigned lanes of IN_W bits become
// IN_LANES/2 lanes of IN_W+1 bits; valid/last travel alongside the data.
module adder_tree_level
  import pca_pkg::*;
#(
  parameter int IN_LANES = 2,
  parameter int IN_W     = PCA_LANE_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  in_valid,
  input  logic                                  in_last,
  input  logic [IN_LANES*IN_W-1:0]              in_data,
  output logic                                  out_valid,
  output logic                                  out_last,
  output logic [(IN_LANES/2)*(IN_W+1)-1:0]      out_data
);

  localparam int OUT_LANES = IN_LANES / 2;
  localparam int OUT_W     = IN_W + 1;

  logic                         valid_r;
  logic                         last_r;
  logic [OUT_LANES*OUT_W-1:0]   data_r;

  // Pairwise adds; the register holds whenever the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      data_r  <= '0;
    end else if (en) begin
      valid_r <= in_valid;
      last_r  <= in_last;
      for (int j = 0; j < OUT_LANES; j++) begin
        data_r[j*OUT_W +: OUT_W] <= OUT_W'(in_data[(2*j)*IN_W +: IN_W])
                                  + OUT_W'(in_data[(2*j+1)*IN_W +: IN_W]);
      end
    end
  end

  assign out_valid = valid_r;
  assign out_last  = last_r;
  assign out_data  = data_r;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined NUM_INPUTS-lane unsigned adder tree with optional in_last-framed
// accumulator and valid/ready handshakes on both sides.
module pipelined_adder_tree
  import pca_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_INPUTS  = 8,
  parameter int ACCUMULATE  = 1,
  parameter int ACC_GUARD   = 8,
  localparam int ACC_W = (ACCUMULATE != 0) ? (2*DATA_WIDTH + clog2(NUM_INPUTS) + ACC_GUARD)
                                           : (2*DATA_WIDTH + clog2(NUM_INPUTS))
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_INPUTS*2*DATA_WIDTH-1:0] in_data,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ACC_W-1:0]                  out_sum,
  output logic                              out_ovf
);

  localparam int LANE_W = lane_width(DATA_WIDTH);
  localparam int LOG2N  = clog2(NUM_INPUTS);
  localparam int TREE_W = LANE_W + LOG2N;

  // All level outputs share one flat bus; these give each level's slice.
  function automatic int lvl_w(input int k);
    return (NUM_INPUTS >> (k + 1)) * (LANE_W + k + 1);
  endfunction

  function automatic int lvl_off(input int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) begin
      s = s + lvl_w(i);
    end
    return s;
  endfunction

  localparam int BUS_W = lvl_off(LOG2N);

  logic               adv_s;
  logic               in_last_s;
  logic [BUS_W-1:0]   lvl_data_s;
  logic [LOG2N-1:0]   lvl_valid_s;
  logic [LOG2N-1:0]   lvl_last_s;
  logic [TREE_W-1:0]  tree_sum_s;
  logic               tree_valid_s;
  logic               tree_last_s;
  logic [ACC_W:0]     acc_sum_s;

  logic [ACC_W-1:0]   acc_r;
  logic               sticky_r;
  logic               out_valid_r;
  logic [ACC_W-1:0]   out_sum_r;
  logic               out_ovf_r;

  assign adv_s     = !out_valid_r || out_ready;
  assign in_ready  = adv_s && !rst;
  assign in_last_s = (ACCUMULATE != 0) ? in_last : 1'b0;

  for (genvar k = 0; k < LOG2N; k++) begin : g_lvl
    localparam int IN_LANES = NUM_INPUTS >> k;
    localparam int IN_W     = LANE_W + k;

    logic [IN_LANES*IN_W-1:0] lvl_in_s;
    logic                     lvl_valid_in_s;
    logic                     lvl_last_in_s;

    if (k == 0) begin : g_first
      assign lvl_in_s       = in_data;
      assign lvl_valid_in_s = in_valid;
      assign lvl_last_in_s  = in_last_s;
    end else begin : g_next
      assign lvl_in_s       = lvl_data_s[lvl_off(k-1) +: lvl_w(k-1)];
      assign lvl_valid_in_s = lvl_valid_s[k-1];
      assign lvl_last_in_s  = lvl_last_s[k-1];
    end

    adder_tree_level #(
      .IN_LANES (IN_LANES),
      .IN_W     (IN_W)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .en        (adv_s),
      .in_valid  (lvl_valid_in_s),
      .in_last   (lvl_last_in_s),
      .in_data   (lvl_in_s),
      .out_valid (lvl_valid_s[k]),
      .out_last  (lvl_last_s[k]),
      .out_data  (lvl_data_s[lvl_off(k) +: lvl_w(k)])
    );
  end

  assign tree_sum_s   = lvl_data_s[lvl_off(LOG2N-1) +: TREE_W];
  assign tree_valid_s = lvl_valid_s[LOG2N-1];
  assign tree_last_s  = lvl_last_s[LOG2N-1];

  // Extra top bit of the add is the accumulator carry-out.
  assign acc_sum_s = {1'b0, acc_r} + (ACC_W+1)'(tree_sum_s);

  // Output stage: accumulator with sticky carry, or a plain result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r       <= '0;
      sticky_r    <= 1'b0;
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_ovf_r   <= 1'b0;
    end else if (adv_s) begin
      if (ACCUMULATE != 0) begin
        if (tree_valid_s && tree_last_s) begin
          out_sum_r   <= acc_sum_s[ACC_W-1:0];
          out_ovf_r   <= sticky_r | acc_sum_s[ACC_W];
          out_valid_r <= 1'b1;
          acc_r       <= '0;
          sticky_r    <= 1'b0;
        end else if (tree_valid_s) begin
          acc_r       <= acc_sum_s[ACC_W-1:0];
          sticky_r    <= sticky_r | acc_sum_s[ACC_W];
          out_valid_r <= 1'b0;
        end else begin
          out_valid_r <= 1'b0;
        end
      end else begin
        out_valid_r <= tree_valid_s;
        out_ovf_r   <= 1'b0;
        if (tree_valid_s) begin
          out_sum_r <= ACC_W'(tree_sum_s);
        end
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed self-checking bench: three configurations of pipelined_adder_tree
// (plain N=4, accumulating N=4, accumulating N=2 with no guard bits).
module tb_pipelined_adder_tree;

  typedef struct {
    logic [31:0] sum;
    logic        ovf;
    int          cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
  logic [63:0] a_in_data;
  logic [17:0] a_out_sum;
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
  logic [63:0] b_in_data;
  logic [25:0] b_out_sum;
  logic        c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready, c_out_ovf;
  logic [31:0] c_in_data;
  logic [16:0] c_out_sum;

  res_t qa[$];
  res_t qb[$];
  res_t qc[$];
  logic        a_hold = 1'b0;
  logic [17:0] a_prev_sum = 18'd0;
  logic        a_saw_stall = 1'b0;

  pipelined_adder_tree #(.DATA_WIDTH(8), .NUM_INPUTS(4), .ACCUMULATE(0), .ACC_GUARD(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf));

  pipelined_adder_tree #(.DATA_WIDTH(8), .NUM_INPUTS(4), .ACCUMULATE(1), .ACC_GUARD(8)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf));

  pipelined_adder_tree #(.DATA_WIDTH(8), .NUM_INPUTS(2), .ACCUMULATE(1), .ACC_GUARD(0)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_last(c_in_last), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .out_ovf(c_out_ovf));

  always #5 clk = ~clk;

  // Cycle stamp for result ordering.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lanes4(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one beat to DUT 0/1/2 and returns just after the accepting edge.
  task automatic send(input int dut, input logic [63:0] d, input logic last);
    logic ok;
    ok = 1'b0;
    case (dut)
      0: begin a_in_data = d; a_in_last = last; a_in_valid = 1'b1; end
      1: begin b_in_data = d; b_in_last = last; b_in_valid = 1'b1; end
      default: begin c_in_data = d[31:0]; c_in_last = last; c_in_valid = 1'b1; end
    endcase
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      case (dut)
        0: ok = a_in_ready;
        1: ok = b_in_ready;
        default: ok = c_in_ready;
      endcase
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    c_in_valid = 1'b0;
    if (!ok) check_value("send_timeout", 64'd0, 64'd1);
  endtask

  // Result capture at handshakes, plus hold checks on the stalled DUT.
  always @(negedge clk) begin
    if (rst) begin
      a_hold = 1'b0;
    end else begin
      if (a_hold) check_value("a_hold_sum", 64'(a_out_sum), 64'(a_prev_sum));
      if (a_out_valid && !a_out_ready) begin
        check_value("a_stall_in_ready", 64'(a_in_ready), 64'd0);
        a_saw_stall = 1'b1;
      end
      a_hold     = a_out_valid && !a_out_ready;
      a_prev_sum = a_out_sum;
      if (a_out_valid && a_out_ready) qa.push_back('{32'(a_out_sum), a_out_ovf, cyc});
      if (b_out_valid && b_out_ready) qb.push_back('{32'(b_out_sum), b_out_ovf, cyc});
      if (c_out_valid && c_out_ready) qc.push_back('{32'(c_out_sum), c_out_ovf, cyc});
    end
  end

  task automatic check_queue(input string tag, input int dut, input int idx,
                             input logic [31:0] exp_sum, input logic exp_ovf);
    res_t r;
    int   sz;
    case (dut)
      0: sz = qa.size();
      1: sz = qb.size();
      default: sz = qc.size();
    endcase
    if (idx < sz) begin
      case (dut)
        0: r = qa[idx];
        1: r = qb[idx];
        default: r = qc[idx];
      endcase
      check_value({tag, "_sum"}, 64'(r.sum), 64'(exp_sum));
      check_value({tag, "_ovf"}, 64'(r.ovf), 64'(exp_ovf));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_last = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_last = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_last = 1'b0; c_in_data = '0; c_out_ready = 1'b1;
    wait_cycles(3);

    check_value("rst_in_ready", 64'(a_in_ready), 64'd0);
    check_value("rst_out_valid", 64'(b_out_valid), 64'd0);
    check_value("rst_out_sum", 64'(b_out_sum), 64'd0);
    check_value("rst_out_ovf", 64'(c_out_ovf), 64'd0);
    rst = 1'b0;
    #1;
    check_value("rel_in_ready_a", 64'(a_in_ready), 64'd1);
    check_value("rel_in_ready_b", 64'(b_in_ready), 64'd1);

    // Latency: result visible LOG2N+1 = 3 cycles after the accepting cycle.
    a_in_data  = lanes4(16'd1, 16'd2, 16'd3, 16'd4);
    a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    cnt = 1;
    while (!a_out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_value("a_latency", 64'(cnt), 64'd3);
    check_value("a_sum_10", 64'(a_out_sum), 64'd10);
    wait_cycles(2);
    qa.delete();

    // Back-to-back beats, then the all-ones width boundary.
    for (int k = 5; k <= 8; k++) send(0, lanes4(16'(k), 16'(k), 16'(k), 16'(k)), 1'b0);
    send(0, lanes4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 1'b0);
    wait_cycles(8);
    check_value("a_b2b_count", 64'(qa.size()), 64'd5);
    check_queue("a_b2b0", 0, 0, 32'd20, 1'b0);
    check_queue("a_b2b1", 0, 1, 32'd24, 1'b0);
    check_queue("a_b2b2", 0, 2, 32'd28, 1'b0);
    check_queue("a_b2b3", 0, 3, 32'd32, 1'b0);
    check_queue("a_ones", 0, 4, 32'h3FFFC, 1'b0);
    for (int i = 1; i < qa.size(); i++) check_value("a_b2b_spacing", 64'(qa[i].cyc - qa[i-1].cyc), 64'd1);
    qa.delete();

    // Backpressure: downstream stalls 5 cycles while a stream is offered.
    a_out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) send(0, lanes4(16'(k), 16'(2*k), 16'(3*k), 16'(4*k)), 1'b0);
      end
      begin
        wait_cycles(5);
        a_out_ready = 1'b1;
      end
    join
    wait_cycles(8);
    check_value("a_bp_stalled", 64'(a_saw_stall), 64'd1);
    check_value("a_bp_count", 64'(qa.size()), 64'd6);
    for (int k = 1; k <= 6; k++) check_queue("a_bp", 0, k - 1, 32'(10 * k), 1'b0);

    // Accumulation groups on B.
    qb.delete();
    send(1, lanes4(16'd1, 16'd1, 16'd1, 16'd1), 1'b0);
    send(1, lanes4(16'd2, 16'd2, 16'd2, 16'd2), 1'b0);
    send(1, lanes4(16'd3, 16'd3, 16'd3, 16'd3), 1'b1);
    send(1, lanes4(16'd5, 16'd0, 16'd0, 16'd0), 1'b1);
    wait_cycles(8);
    check_value("b_group_count", 64'(qb.size()), 64'd2);
    check_queue("b_group24", 1, 0, 32'd24, 1'b0);
    check_queue("b_single5", 1, 1, 32'd5, 1'b0);

    // Carry-out of a zero-guard accumulator, sticky across beats, then cleared.
    qc.delete();
    send(2, {32'd0, 16'hFFFF, 16'hFFFF}, 1'b0);
    send(2, {32'd0, 16'hFFFF, 16'hFFFF}, 1'b1);
    send(2, {32'd0, 16'd2, 16'd1}, 1'b1);
    send(2, {32'd0, 16'hFFFF, 16'hFFFF}, 1'b0);
    send(2, {32'd0, 16'hFFFF, 16'hFFFF}, 1'b0);
    send(2, 64'd0, 1'b1);
    send(2, {32'd0, 16'd0, 16'd7}, 1'b1);
    wait_cycles(8);
    check_value("c_group_count", 64'(qc.size()), 64'd4);
    check_queue("c_ovf", 2, 0, 32'h1FFFC, 1'b1);
    check_queue("c_after_ovf", 2, 1, 32'd3, 1'b0);
    check_queue("c_sticky", 2, 2, 32'h1FFFC, 1'b1);
    check_queue("c_after_sticky", 2, 3, 32'd7, 1'b0);

    // Reset in the middle of a B group discards the partial sum.
    qb.delete();
    send(1, lanes4(16'd1, 16'd1, 16'd1, 16'd1), 1'b0);
    send(1, lanes4(16'd2, 16'd2, 16'd2, 16'd2), 1'b0);
    wait_cycles(5);
    rst = 1'b1;
    #1;
    check_value("mid_rst_out_valid", 64'(b_out_valid), 64'd0);
    check_value("mid_rst_out_sum", 64'(b_out_sum), 64'd0);
    check_value("mid_rst_in_ready", 64'(b_in_ready), 64'd0);
    wait_cycles(2);
    rst = 1'b0;
    send(1, lanes4(16'd1, 16'd1, 16'd1, 16'd1), 1'b1);
    wait_cycles(8);
    check_value("post_rst_count", 64'(qb.size()), 64'd1);
    check_queue("post_rst", 1, 0, 32'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
